shift_frame_rx: RTL and testbench
=================================

// Module: shift_frame_rx
// PURPOSE
//  Receiver for the serial shift-out frames (clock/data/enable) produced by our GPIO LED and
//  Display segment drivers. Samples sclk/sdi/sen asynchronously in the clk domain and
//  reassembles FRAME_W-bit words. Presents each word to MIO as a read register with a
//  valid/read-strobe handshake.
//  Uses: board-to-board links, loopback self-test of the LED/segment drivers, CPU-visible
//  capture of shifted frames.
// PARAMETERS
//  FRAME_W   16  bits per frame (16 for LED chain, 64 for segment chain)
//  CNT_W     7   bit-counter width; must hold FRAME_W+1
// PORTS
//  clk        in   1        system clock (clk_100mhz domain); all state on posedge
//  rst        in   1        synchronous, active-high reset
//  sclk       in   1        serial shift clock, async to clk
//  sdi        in   1        serial data, MSB first, valid at sclk rising edge
//  sen        in   1        frame enable: low = shifting, rising edge = latch
//  rd_en      in   1        MIO read strobe; 1-cycle pulse acknowledges rx_data
//  rx_data    out  FRAME_W  last complete frame, bit[FRAME_W-1] = first bit received
//  rx_valid   out  1        rx_data holds an unread frame
//  frame_err  out  1        sticky: a latched frame had bit count != FRAME_W
//  overrun    out  1        sticky: a frame completed while rx_valid was already 1
//  busy       out  1        high in SHIFT state
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): state IDLE, rx_data=0, rx_valid=0, frame_err=0,
//  overrun=0, busy=0, shift reg/count=0, synchronizers preset to 1 (sclk,sen idle high).
//  Input path: each of sclk/sen/sdi passes a 2-flop synchronizer. Edge detect compares the
//  synced value with its previous value. sdi is sampled from the synchronizer stage aligned
//  with the sclk rise.
//  Timing: sclk/sen high/low time >= 3 clk cycles (>= 4 with filter enabled).
//  FSM:
//   IDLE  : wait for synced sen==1 then a sen fall -> SHIFT, clear cnt and shift reg.
//           sclk edges ignored. A post-reset sen held low is ignored until it goes high.
//   SHIFT : on each sclk rise: sreg <= {sreg[FRAME_W-2:0], sdi}; cnt saturates at FRAME_W+1.
//           sen rise -> LATCH.
//   LATCH : one cycle, then -> IDLE. Actions by cnt:
//           cnt==FRAME_W: rx_data<=sreg, rx_valid<=1; overrun<=1 if rx_valid was 1 and
//           rd_en is 0 this cycle.
//           cnt!=FRAME_W (short or long): frame_err<=1; rx_data/rx_valid unchanged.
//  Latency: rx_valid rises 4 clk edges after the first clk edge that samples sen high at the pin.
//  Handshake: rd_en with rx_valid=1 clears rx_valid, frame_err and overrun on the next edge.
//   rd_en with rx_valid=0 clears only the sticky flags.
//   rd_en in the same cycle as a LATCH success: new data wins, rx_valid stays 1, no overrun.
//  sclk rise and sen rise in the same synced cycle: the bit is shifted first, then LATCH.
//  rst during SHIFT aborts the partial frame silently (no frame_err).
// CONFIGURATION
//  `SFRX_GLITCH_FILTER_EN defined: sclk and sen each pass a 2-sample agreement filter after
//   the synchronizer. The filtered value changes only when two consecutive synced samples
//   agree. Adds +1 clk latency (rx_valid at 5 edges); min pulse width becomes 4 clk.
//  Undefined: no filter; latency as above. A single-cycle glitch counts as an edge.
// STRUCTURE
//  Package sfrx_pkg: state encoding (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_LATCH=2'd2), SYNC_STAGES=2.
//  Sub-module sfrx_sync_edge (instantiated for sclk and sen): synchronizer, optional
//  filter, outputs lvl/rise/fall.
//  sdi uses a plain 2-flop delay matched to sclk's pipeline.
// TESTING
//  1 FRAME_W=16, shift 16'hA5C3 MSB-first, half-period 5 clk, sen rise -> rx_valid=1,
//    rx_data=16'hA5C3 at latency 4 (5 with filter), frame_err=0.
//  2 Short frame of 15 bits then sen rise -> frame_err=1, rx_valid stays 0; a following good
//    16'h0001 frame -> rx_valid=1, rx_data=16'h0001.
//  3 Two good frames 16'h1111, 16'h2222, no rd_en -> rx_data=16'h2222, overrun=1.
//    A rd_en pulse then -> rx_valid=0, overrun=0.
//  4 rd_en asserted in the exact LATCH cycle of frame 16'hBEEF -> rx_valid=1, overrun=0.
//  5 rst pulsed after 8 bits, then a full 16'hFFFF frame -> only 16'hFFFF captured, no frame_err.
//  6 With filter: a 1-clk sclk glitch mid-frame is not counted, and 16'h8001 is received
//    intact. Without filter: the same stimulus -> frame_err=1.

Source files
------------

// File: rtl/sfrx_pkg.sv
// Shared types and constants for the shift_frame_rx receiver.
// Optional build macro: SFRX_GLITCH_FILTER_EN (2-sample agreement filter on sclk/sen).
package sfrx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

`ifdef SFRX_GLITCH_FILTER_EN
  localparam int FILT_STAGES = 1;
`else
  localparam int FILT_STAGES = 0;
`endif

  // sdi must lag by exactly as many flops as the registered sclk rise strobe
  localparam int SDI_DEPTH = SYNC_STAGES + 1 + FILT_STAGES;

  // cycles after reset before the sen level reflects the pin rather than the preset
  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 2);

endpackage

// File: rtl/sfrx_sync_edge.sv
// Synchronizes one async strobe into clk and emits registered level/rise/fall.
// Latency: 3 clk from pin to rise/fall (4 with SFRX_GLITCH_FILTER_EN); no backpressure.
// Flops preset to 1 so an idle-high line produces no edge out of reset.
module sfrx_sync_edge
  import sfrx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cand;
  logic                   held;

  always_comb begin
`ifdef SFRX_GLITCH_FILTER_EN
    // level only moves once two consecutive synced samples agree
    held = lvl;
    cand = (sync_q[SYNC_STAGES-1] == prev_q) ? prev_q : lvl;
`else
    held = prev_q;
    cand = sync_q[SYNC_STAGES-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      lvl    <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      lvl    <= cand;
      rise   <= cand & ~held;
      fall   <= ~cand & held;
    end
  end

endmodule

// File: rtl/shift_frame_rx.sv
// Reassembles MSB-first serial frames (sclk/sdi/sen) into FRAME_W-bit words for MIO reads.
// Latency: rx_valid 4 clk edges after sen high is first sampled (5 with SFRX_GLITCH_FILTER_EN).
// No backpressure: an unread word is overwritten and flagged by sticky overrun.
module shift_frame_rx
  import sfrx_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               sdi,
  input  logic               sen,
  input  logic               rd_en,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   sreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SDI_DEPTH-1:0] sdi_q;
  logic [2:0]           warm_q;
  logic                 armed_q;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sen_lvl, sen_rise, sen_fall;
  logic unused_sclk;

  sfrx_sync_edge u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .lvl  (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sfrx_sync_edge u_sen_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sen),
    .lvl  (sen_lvl),
    .rise (sen_rise),
    .fall (sen_fall)
  );

  assign unused_sclk = sclk_lvl ^ sclk_fall;
  assign busy        = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sen_fall && armed_q) state_d = ST_SHIFT;
      ST_SHIFT: if (sen_rise) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sdi_q   <= '0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sdi_q   <= {sdi_q[SDI_DEPTH-2:0], sdi};
      if (warm_q != WARM_CYCLES) warm_q <= warm_q + 3'd1;
      // a frame may only start after sen has been seen high from the real pin
      if (state_q == ST_IDLE && state_d == ST_SHIFT) armed_q <= 1'b0;
      else if (warm_q == WARM_CYCLES && sen_lvl)    armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_SHIFT) begin
        sreg_q <= '0;
        cnt_q  <= '0;
      end

      if (state_q == ST_SHIFT && sclk_rise) begin
        sreg_q <= {sreg_q[FRAME_W-2:0], sdi_q[SDI_DEPTH-1]};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end

      if (rd_en) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end

      // latch results override a same-cycle read acknowledge
      if (state_q == ST_LATCH) begin
        if (cnt_q == CNT_FULL) begin
          rx_data  <= sreg_q;
          rx_valid <= 1'b1;
          if (rx_valid && !rd_en) overrun <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_frame_rx.sv
// Self-checking bench for shift_frame_rx: directed scenarios plus randomized frames vs a word-level model.
// Honours SFRX_GLITCH_FILTER_EN for latency and glitch expectations.
module tb_shift_frame_rx;

  localparam int FRAME_W = 16;
`ifdef SFRX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic               clk = 1'b0;
  logic               rst, sclk, sdi, sen, rd_en;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid, frame_err, overrun, busy;

  int n_pass = 0;
  int n_chk  = 0;

  logic [FRAME_W-1:0] m_data;
  bit                 m_valid, m_ferr, m_ovr;

  shift_frame_rx #(.FRAME_W(FRAME_W), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sdi       (sdi),
    .sen       (sen),
    .rd_en     (rd_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic model_read();
    m_valid = 0; m_ferr = 0; m_ovr = 0;
  endtask

  // A frame is accepted only with exactly FRAME_W bits; the word is the bits sent, first bit = MSB.
  task automatic model_frame(input logic [31:0] val, input int nbits, input bit rd_same);
    bit was_valid;
    was_valid = m_valid;
    if (rd_same) model_read();
    if (nbits == FRAME_W) begin
      m_data  = val[FRAME_W-1:0];
      m_valid = 1;
      if (was_valid && !rd_same) m_ovr = 1;
    end else begin
      m_ferr = 1;
    end
  endtask

  // sen low, then nbits of val MSB first; optional 1-clk low glitch in the high phase of bit glitch_at
  task automatic drive_bits(input logic [31:0] val, input int nbits, input int glitch_at);
    sen = 1'b0;
    tick(5);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = 1'b0;
      sdi  = val[i];
      tick(5);
      sclk = 1'b1;
      if (nbits - 1 - i == glitch_at) begin
        tick(2); sclk = 1'b0; tick(1); sclk = 1'b1; tick(2);
      end else begin
        tick(5);
      end
    end
  endtask

  // raise sen at a negedge; rd_en is held across the rd_at-th following posedge
  task automatic close_frame(input int rd_at, output int first_vld);
    first_vld = -1;
    sen = 1'b1;
    rd_en = (rd_at == 0);
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(1);
      if (first_vld < 0 && rx_valid === 1'b1) first_vld = k;
      rd_en = (k == rd_at);
    end
    rd_en = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1; tick(1); rd_en = 1'b0; tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_chk++; if (rx_data !== '0)    $display("FAIL reset_data got %h exp 0", rx_data);  else n_pass++;
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_valid); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_err); else n_pass++;
    n_chk++; if (overrun !== 1'b0)  $display("FAIL reset_ovr got %b exp 0", overrun);   else n_pass++;
    n_chk++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b exp 0", busy);     else n_pass++;
    rst = 1'b0;
    model_reset();
    tick(10);
  endtask

  task automatic test_basic();
    int fv;
    drive_bits(32'hA5C3, 16, -1);
    n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else n_pass++;
    close_frame(-1, fv);
    model_frame(32'hA5C3, 16, 0);
    n_chk++; if (fv !== LAT + 1) $display("FAIL basic_latency got %0d exp %0d", fv, LAT + 1); else n_pass++;
    n_chk++; if (rx_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", rx_valid); else n_pass++;
    n_chk++; if (rx_data !== 16'hA5C3) $display("FAIL basic_data got %h exp a5c3", rx_data); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL basic_ferr got %b exp 0", frame_err); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b exp 0", busy); else n_pass++;
    pulse_rd(); model_read();
  endtask

  task automatic test_short();
    int fv;
    drive_bits(32'h7FFF, 15, -1);
    close_frame(-1, fv);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL short_ferr got %b exp 1", frame_err); else n_pass++;
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL short_valid got %b exp 0", rx_valid); else n_pass++;
    drive_bits(32'h0001, 16, -1);
    close_frame(-1, fv);
    n_chk++; if (rx_valid !== 1'b1) $display("FAIL short_next_valid got %b exp 1", rx_valid); else n_pass++;
    n_chk++; if (rx_data !== 16'h0001) $display("FAIL short_next_data got %h exp 0001", rx_data); else n_pass++;
    n_chk++; if (frame_err !== 1'b1) $display("FAIL short_sticky got %b exp 1", frame_err); else n_pass++;
    pulse_rd();
    n_chk++; if (frame_err !== 1'b0) $display("FAIL short_ferr_clr got %b exp 0", frame_err); else n_pass++;
    model_frame(32'h7FFF, 15, 0); model_frame(32'h0001, 16, 0); model_read();
  endtask

  task automatic test_overrun();
    int fv;
    drive_bits(32'h1111, 16, -1); close_frame(-1, fv);
    drive_bits(32'h2222, 16, -1); close_frame(-1, fv);
    n_chk++; if (rx_data !== 16'h2222) $display("FAIL ovr_data got %h exp 2222", rx_data); else n_pass++;
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b exp 1", overrun); else n_pass++;
    pulse_rd();
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL ovr_rd_valid got %b exp 0", rx_valid); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_rd_flag got %b exp 0", overrun); else n_pass++;
    model_frame(32'h1111, 16, 0); model_frame(32'h2222, 16, 0); model_read();
  endtask

  task automatic test_rd_in_latch();
    int fv;
    drive_bits(32'h1234, 16, -1); close_frame(-1, fv);
    drive_bits(32'hBEEF, 16, -1); close_frame(LAT, fv);
    n_chk++; if (rx_valid !== 1'b1) $display("FAIL rdlatch_valid got %b exp 1", rx_valid); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL rdlatch_ovr got %b exp 0", overrun); else n_pass++;
    n_chk++; if (rx_data !== 16'hBEEF) $display("FAIL rdlatch_data got %h exp beef", rx_data); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int fv;
    drive_bits(32'h00AA, 8, -1);
    rst = 1'b1; tick(2); rst = 1'b0;
    model_reset();
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", rx_valid); else n_pass++;
    sen = 1'b1;
    tick(12);
    n_chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr got %b exp 0", frame_err); else n_pass++;
    drive_bits(32'hFFFF, 16, -1); close_frame(-1, fv);
    model_frame(32'hFFFF, 16, 0);
    n_chk++; if (rx_data !== 16'hFFFF) $display("FAIL rstmid_data got %h exp ffff", rx_data); else n_pass++;
    n_chk++; if (rx_valid !== 1'b1) $display("FAIL rstmid_valid2 got %b exp 1", rx_valid); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr2 got %b exp 0", frame_err); else n_pass++;
    pulse_rd(); model_read();
  endtask

  task automatic test_glitch();
    int fv;
    drive_bits(32'h8001, 16, 7);
    close_frame(-1, fv);
`ifdef SFRX_GLITCH_FILTER_EN
    model_frame(32'h8001, 16, 0);
    n_chk++; if (rx_data !== 16'h8001) $display("FAIL glitch_data got %h exp 8001", rx_data); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL glitch_ferr got %b exp 0", frame_err); else n_pass++;
`else
    model_frame(32'h8001, 17, 0);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL glitch_ferr got %b exp 1", frame_err); else n_pass++;
    n_chk++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid got %b exp 0", rx_valid); else n_pass++;
`endif
    pulse_rd(); model_read();
  endtask

  task automatic test_random();
    int fv, nbits, mode, sel;
    logic [31:0] val;
    for (int it = 0; it < 30; it++) begin
      val = $urandom;
      sel = $urandom_range(0, 5);
      if (sel < 3)       nbits = FRAME_W;
      else if (sel == 3) nbits = $urandom_range(1, FRAME_W - 1);
      else               nbits = $urandom_range(FRAME_W + 1, FRAME_W + 4);
      mode = $urandom_range(0, 3);
      if (mode == 1) begin pulse_rd(); model_read(); end
      drive_bits(val, nbits, -1);
      close_frame((mode == 0) ? LAT : -1, fv);
      model_frame(val, nbits, mode == 0);
      n_chk++; if (rx_valid !== m_valid) $display("FAIL rnd%0d_valid got %b exp %b", it, rx_valid, m_valid); else n_pass++;
      n_chk++; if (rx_data !== m_data) $display("FAIL rnd%0d_data got %h exp %h", it, rx_data, m_data); else n_pass++;
      n_chk++; if (frame_err !== m_ferr) $display("FAIL rnd%0d_ferr got %b exp %b", it, frame_err, m_ferr); else n_pass++;
      n_chk++; if (overrun !== m_ovr) $display("FAIL rnd%0d_ovr got %b exp %b", it, overrun, m_ovr); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b1; sen = 1'b1; sdi = 1'b0; rd_en = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_overrun();
    test_rd_in_latch();
    test_reset_mid_frame();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
